// File: rtl/main_data_reservoir.sv
`default_nettype none
// ============================================================================
// Module   : main_data_reservoir
// Purpose  : MP3 main-data bit reservoir. A circular byte RAM is served back one
//            bit per request, MSB first, and re-aligned on main_data_begin.
// Revision : 1.0  initial release
// ============================================================================
module main_data_reservoir #(
    parameter int DEPTH_BYTES = 2048,
    parameter int COUNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid_in,
    output logic               byte_ready_out,
    input  logic               si_valid_in,
    input  logic [8:0]         main_data_begin,
    input  logic               rea,
    output logic               data_out,
    output logic               data_valid,
    output logic [COUNT_W-1:0] data_count,
    output logic               mdb_err
);

    localparam int AW     = $clog2(DEPTH_BYTES);
    localparam int PTR_W  = AW + 1;
    localparam int BITS_W = PTR_W + 3;
    localparam int SUM_W  = (BITS_W > COUNT_W) ? BITS_W : COUNT_W;

    localparam logic [PTR_W-1:0] C_DEPTH_PTR = PTR_W'(DEPTH_BYTES);
    localparam logic [PTR_W-1:0] C_PTR_ONE   = PTR_W'(1);
    localparam logic [SUM_W-1:0] C_CNT_MAX   = SUM_W'({COUNT_W{1'b1}});

    typedef enum logic [0:0] {
        ST_STREAM = 1'b0,
        ST_ALIGN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   base_ptr_q, base_ptr_d;
    logic [PTR_W-1:0]   rd_byte_q, rd_byte_d;
    logic [2:0]         rd_bit_q, rd_bit_d;
    logic [PTR_W-1:0]   bnd_q, bnd_d;
    logic [8:0]         mdb_q, mdb_d;
    logic               pend_q, pend_d;
    logic [PTR_W-1:0]   pend_bnd_q, pend_bnd_d;
    logic [8:0]         pend_mdb_q, pend_mdb_d;
    logic [COUNT_W-1:0] data_count_q, data_count_d;
    logic               data_valid_q, data_valid_d;
    logic               mdb_err_q, mdb_err_d;
    logic [2:0]         rd_sel_q, rd_sel_d;
    logic [7:0]         rd_word_q;

    logic [7:0]         mem [DEPTH_BYTES];

    logic [PTR_W-1:0]   w_stored;
    logic               w_full;
    logic               w_wr_en;
    logic               w_start;
    logic               w_rd_en;
    logic [PTR_W-1:0]   w_target;
    logic               w_mdb_ok;
    logic [PTR_W-1:0]   w_diff;
    logic [BITS_W-1:0]  w_bits;
    logic [SUM_W-1:0]   w_bits_ext;

    // Bytes stay retained until an alignment moves base_ptr forward.
    assign w_stored = wr_ptr_q - base_ptr_q;
    assign w_full   = (w_stored == C_DEPTH_PTR);
    assign w_wr_en  = byte_valid_in && !w_full;
    assign w_start  = (state_q == ST_STREAM) && (si_valid_in || pend_q);
    assign w_rd_en  = (state_q == ST_STREAM) && !w_start && rea && (data_count_q != '0);
    assign w_target = bnd_q - PTR_W'(mdb_q);
    assign w_mdb_ok = (PTR_W'(mdb_q) <= (bnd_q - base_ptr_q));

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem[wr_ptr_q[AW-1:0]] <= byte_in;
        end
    end

    always_ff @(posedge clk) begin
        if (w_rd_en) begin
            rd_word_q <= mem[rd_byte_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_STREAM;
            wr_ptr_q     <= '0;
            base_ptr_q   <= '0;
            rd_byte_q    <= '0;
            rd_bit_q     <= '0;
            bnd_q        <= '0;
            mdb_q        <= '0;
            pend_q       <= 1'b0;
            pend_bnd_q   <= '0;
            pend_mdb_q   <= '0;
            data_count_q <= '0;
            data_valid_q <= 1'b0;
            mdb_err_q    <= 1'b0;
            rd_sel_q     <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            base_ptr_q   <= base_ptr_d;
            rd_byte_q    <= rd_byte_d;
            rd_bit_q     <= rd_bit_d;
            bnd_q        <= bnd_d;
            mdb_q        <= mdb_d;
            pend_q       <= pend_d;
            pend_bnd_q   <= pend_bnd_d;
            pend_mdb_q   <= pend_mdb_d;
            data_count_q <= data_count_d;
            data_valid_q <= data_valid_d;
            mdb_err_q    <= mdb_err_d;
            rd_sel_q     <= rd_sel_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        base_ptr_d   = base_ptr_q;
        rd_byte_d    = rd_byte_q;
        rd_bit_d     = rd_bit_q;
        bnd_d        = bnd_q;
        mdb_d        = mdb_q;
        pend_d       = pend_q;
        pend_bnd_d   = pend_bnd_q;
        pend_mdb_d   = pend_mdb_q;
        data_valid_d = w_rd_en;
        mdb_err_d    = 1'b0;
        rd_sel_d     = rd_sel_q;

        if (w_wr_en) begin
            wr_ptr_d = wr_ptr_q + C_PTR_ONE;
        end

        case (state_q)
            ST_STREAM: begin
                if (w_start) begin
                    state_d = ST_ALIGN;
                    // A deferred side info is served first; a fresh one then waits.
                    if (pend_q) begin
                        bnd_d  = pend_bnd_q;
                        mdb_d  = pend_mdb_q;
                        pend_d = si_valid_in;
                        if (si_valid_in) begin
                            pend_bnd_d = wr_ptr_q;
                            pend_mdb_d = main_data_begin;
                        end
                    end else begin
                        bnd_d = wr_ptr_q;
                        mdb_d = main_data_begin;
                    end
                end else if (w_rd_en) begin
                    rd_sel_d = rd_bit_q;
                    rd_bit_d = rd_bit_q + 3'd1;
                    if (rd_bit_q == 3'd7) begin
                        rd_byte_d = rd_byte_q + C_PTR_ONE;
                    end
                end
            end
            ST_ALIGN: begin
                state_d  = ST_STREAM;
                rd_bit_d = '0;
                if (w_mdb_ok) begin
                    rd_byte_d  = w_target;
                    base_ptr_d = w_target;
                end else begin
                    rd_byte_d = base_ptr_q;
                    mdb_err_d = 1'b1;
                end
                if (si_valid_in) begin
                    pend_d     = 1'b1;
                    pend_bnd_d = wr_ptr_q;
                    pend_mdb_d = main_data_begin;
                end
            end
            default: begin
                state_d = ST_STREAM;
            end
        endcase
    end

    // Count is derived from next-state pointers so it is exact in every cycle.
    always_comb begin
        w_diff     = wr_ptr_d - rd_byte_d;
        w_bits     = {w_diff, 3'b000} - BITS_W'(rd_bit_d);
        w_bits_ext = SUM_W'(w_bits);
        if (state_d == ST_ALIGN) begin
            data_count_d = '0;
        end else if (w_bits_ext > C_CNT_MAX) begin
            data_count_d = COUNT_W'(C_CNT_MAX);
        end else begin
            data_count_d = COUNT_W'(w_bits_ext);
        end
    end

    assign byte_ready_out = !w_full;
    assign data_valid     = data_valid_q;
    assign data_out       = data_valid_q & rd_word_q[3'd7 - rd_sel_q];
    assign data_count     = data_count_q;
    assign mdb_err        = mdb_err_q;

endmodule
`default_nettype wire

// File: tb/tb_main_data_reservoir.sv
`default_nettype none
// Bench for main_data_reservoir: vector table, directed corner sequences and
// randomized traffic against an absolute-index reference model.
module tb_main_data_reservoir;

    localparam int DEPTH = 2048;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    byte_in;
    logic          byte_valid_in;
    logic          byte_ready_out;
    logic          si_valid_in;
    logic [8:0]    main_data_begin;
    logic          rea;
    logic          data_out;
    logic          data_valid;
    logic [CW-1:0] data_count;
    logic          mdb_err;

    main_data_reservoir #(.DEPTH_BYTES(DEPTH), .COUNT_W(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .byte_in         (byte_in),
        .byte_valid_in   (byte_valid_in),
        .byte_ready_out  (byte_ready_out),
        .si_valid_in     (si_valid_in),
        .main_data_begin (main_data_begin),
        .rea             (rea),
        .data_out        (data_out),
        .data_valid      (data_valid),
        .data_count      (data_count),
        .mdb_err         (mdb_err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: byte stream indexed by absolute (never wrapping) position.
    logic [7:0] mem_m [int];
    int  m_wr, m_base, m_rdpos, m_count;
    int  m_bnd, m_mdb, m_pbnd, m_pmdb;
    bit  m_align, m_pend;
    bit  e_valid, e_out, e_err;

    typedef struct {
        logic       bv;
        logic [7:0] b;
        logic       si;
        logic [8:0] mdb;
        logic       rd;
        logic       e_valid;
        logic       e_out;
        int         e_count;
    } vec_t;

    vec_t vt [20];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_wr = 0; m_base = 0; m_rdpos = 0; m_count = 0;
        m_bnd = 0; m_mdb = 0; m_pbnd = 0; m_pmdb = 0;
        m_align = 0; m_pend = 0;
        e_valid = 0; e_out = 0; e_err = 0;
    endtask

    task automatic model_update(input logic bv, input logic [7:0] b, input logic si,
                                input logic [8:0] mdb, input logic rd, input logic r);
        bit         full, nxt_align;
        logic [7:0] bb;
        int         bits;
        if (r) begin
            model_reset();
            return;
        end
        full      = ((m_wr - m_base) == DEPTH);
        e_valid   = 0;
        e_err     = 0;
        nxt_align = 0;
        if (!m_align) begin
            if (si || m_pend) begin
                nxt_align = 1;
                if (m_pend) begin
                    m_bnd  = m_pbnd;
                    m_mdb  = m_pmdb;
                    m_pend = si;
                    if (si) begin
                        m_pbnd = m_wr;
                        m_pmdb = int'(mdb);
                    end
                end else begin
                    m_bnd = m_wr;
                    m_mdb = int'(mdb);
                end
            end else if (rd && m_count != 0) begin
                bb      = mem_m[m_rdpos / 8];
                e_out   = bb[7 - (m_rdpos % 8)];
                e_valid = 1;
                m_rdpos++;
            end
        end else begin
            if (m_mdb <= m_bnd - m_base) begin
                m_base  = m_bnd - m_mdb;
                m_rdpos = 8 * m_base;
            end else begin
                m_rdpos = 8 * m_base;
                e_err   = 1;
            end
            if (si) begin
                m_pend = 1;
                m_pbnd = m_wr;
                m_pmdb = int'(mdb);
            end
        end
        if (bv && !full) begin
            mem_m[m_wr] = b;
            m_wr++;
        end
        m_align = nxt_align;
        bits    = 8 * m_wr - m_rdpos;
        m_count = nxt_align ? 0 : ((bits > 65535) ? 65535 : bits);
    endtask

    task automatic step(input logic bv, input logic [7:0] b, input logic si,
                        input logic [8:0] mdb, input logic rd, input logic r);
        byte_valid_in   = bv;
        byte_in         = b;
        si_valid_in     = si;
        main_data_begin = mdb;
        rea             = rd;
        rst             = r;
        @(posedge clk);
        model_update(bv, b, si, mdb, rd, r);
        #1;
        chk("m_valid", int'(data_valid), int'(e_valid));
        if (e_valid) chk("m_out", int'(data_out), int'(e_out));
        chk("m_count", int'(data_count), m_count);
        chk("m_err", int'(mdb_err), int'(e_err));
        chk("m_ready", int'(byte_ready_out), int'((m_wr - m_base) != DEPTH));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'h00, 1'b0, 9'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 8'h00, 1'b0, 9'd0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 9'd0, 1'b0, 1'b0);
    endtask

    task automatic write_b0_b9();
        for (int k = 0; k < 10; k++) step(1'b1, 8'hB0 + 8'(k), 1'b0, 9'd0, 1'b0, 1'b0);
    endtask

    task automatic read_bits(input int n, output logic [31:0] acc);
        acc = '0;
        for (int k = 0; k < n; k++) begin
            step(1'b0, 8'h00, 1'b0, 9'd0, 1'b1, 1'b0);
            acc = {acc[30:0], data_out};
        end
    endtask

    logic [15:0] pat;
    logic [31:0] acc;

    initial begin
        byte_in = '0; byte_valid_in = 0; si_valid_in = 0; main_data_begin = '0;
        rea = 0; rst = 1;
        model_reset();

        // Reset state
        do_reset();
        chk("rst_valid", int'(data_valid), 0);
        chk("rst_count", int'(data_count), 0);
        chk("rst_ready", int'(byte_ready_out), 1);
        chk("rst_err", int'(mdb_err), 0);
        chk("rst_out", int'(data_out), 0);

        // Vector table: si, two writes, 16 reads, one read past empty
        pat   = 16'hA53C;
        vt[0] = '{1'b0, 8'h00, 1'b1, 9'd0, 1'b0, 1'b0, 1'b0, 0};
        vt[1] = '{1'b1, 8'hA5, 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 8};
        vt[2] = '{1'b1, 8'h3C, 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 16};
        for (int i = 0; i < 16; i++)
            vt[3+i] = '{1'b0, 8'h00, 1'b0, 9'd0, 1'b1, 1'b1, pat[15-i], 15 - i};
        vt[19] = '{1'b0, 8'h00, 1'b0, 9'd0, 1'b1, 1'b0, 1'b0, 0};
        for (int i = 0; i < 20; i++) begin
            step(vt[i].bv, vt[i].b, vt[i].si, vt[i].mdb, vt[i].rd, 1'b0);
            chk("tv_valid", int'(data_valid), int'(vt[i].e_valid));
            if (vt[i].e_valid) chk("tv_out", int'(data_out), int'(vt[i].e_out));
            chk("tv_count", int'(data_count), vt[i].e_count);
        end

        // Backward re-alignment by three bytes
        do_reset();
        step(1'b0, 8'h00, 1'b1, 9'd0, 1'b0, 1'b0);
        idle(1);
        write_b0_b9();
        read_bits(40, acc);
        step(1'b0, 8'h00, 1'b1, 9'd3, 1'b0, 1'b0);
        idle(1);
        chk("back_count", int'(data_count), 24);
        chk("back_err", int'(mdb_err), 0);
        read_bits(24, acc);
        chk("back_bits", int'(acc[23:0]), int'(24'hB7B8B9));

        // main_data_begin beyond retained bytes
        do_reset();
        step(1'b0, 8'h00, 1'b1, 9'd0, 1'b0, 1'b0);
        idle(1);
        write_b0_b9();
        read_bits(5, acc);
        step(1'b0, 8'h00, 1'b1, 9'd20, 1'b0, 1'b0);
        idle(1);
        chk("err_pulse", int'(mdb_err), 1);
        chk("err_count", int'(data_count), 80);
        idle(1);
        chk("err_clear", int'(mdb_err), 0);
        read_bits(8, acc);
        chk("err_restart", int'(acc[7:0]), int'(8'hB0));

        // Fill to capacity, drop the extra byte, then free by alignment
        do_reset();
        step(1'b0, 8'h00, 1'b1, 9'd0, 1'b0, 1'b0);
        idle(1);
        for (int k = 0; k < DEPTH; k++) step(1'b1, 8'($urandom), 1'b0, 9'd0, 1'b0, 1'b0);
        chk("full_ready", int'(byte_ready_out), 0);
        chk("full_count", int'(data_count), 8 * DEPTH);
        step(1'b1, 8'h5A, 1'b0, 9'd0, 1'b0, 1'b0);
        chk("full_drop", int'(data_count), 8 * DEPTH);
        step(1'b0, 8'h00, 1'b1, 9'd0, 1'b0, 1'b0);
        idle(1);
        chk("free_ready", int'(byte_ready_out), 1);

        // Reset in the middle of a read burst
        do_reset();
        step(1'b0, 8'h00, 1'b1, 9'd0, 1'b0, 1'b0);
        idle(1);
        for (int k = 0; k < 4; k++) step(1'b1, 8'hC0 + 8'(k), 1'b0, 9'd0, 1'b0, 1'b0);
        read_bits(10, acc);
        step(1'b0, 8'h00, 1'b0, 9'd0, 1'b1, 1'b1);
        chk("mrst_valid", int'(data_valid), 0);
        chk("mrst_count", int'(data_count), 0);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 8'h00, 1'b0, 9'd0, 1'b1, 1'b0);
            chk("mrst_noserve", int'(data_valid), 0);
        end

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            logic       bv, si, rd, r;
            logic [8:0] mdb;
            bv  = ($urandom_range(0, 99) < 55);
            rd  = ($urandom_range(0, 99) < 75);
            si  = ($urandom_range(0, 99) < 4);
            r   = ($urandom_range(0, 999) < 2);
            mdb = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(0, 511))
                                              : 9'($urandom_range(0, 40));
            step(bv, 8'($urandom), si, mdb, rd, r);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
